j_xfer_sched: RTL

Two-channel transfer scheduler for Jerry that shares one size-decrement datapath (23-bit address minus 1/2/4-byte transfer size) and one bus request port between channels.
- Each channel holds a 23-bit current address, a 23-bit remaining byte length and a size code.
- The scheduler arbitrates round-robin, issues one bus transfer per grant and decrements the address and length after each acknowledge.
- It signals completion per channel.

---
 rtl/j_xfer_sched.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/j_xfer_sched.sv
// Two-channel transfer scheduler. Both channels share a single bus request
// port and one address/length decrement datapath. Grants alternate
// round-robin, and each grant issues exactly one bus transfer.
//
// Bus handshake: bus_req is the valid and bus_ack is the ready. A transfer
// happens on the rising edge where bus_req=1 and bus_ack=1. While bus_req=1,
// bus_ch/bus_addr/bus_size/bus_last stay constant, and bus_req is not
// dropped before that edge. bus_ack is ignored while bus_req=0.
module j_xfer_sched #(
  parameter int AW  = 23,
  parameter int NCH = 2
) (
  input  logic           sys_clk,
  input  logic           reset,
  input  logic           cfg_we,
  input  logic           cfg_ch,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [AW-1:0]  cfg_len,
  input  logic [1:0]     cfg_size,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] abort,
  output logic           bus_req,
  input  logic           bus_ack,
  output logic           bus_ch,
  output logic [AW-1:0]  bus_addr,
  output logic [1:0]     bus_size,
  output logic           bus_last,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done,
  output logic [1:0]     dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARB  = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_UPD  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic                    last_ch_q, last_ch_d;
  logic [NCH-1:0]          busy_q, busy_d;
  logic [NCH-1:0]          done_q, done_d;
  logic                    abort_pend_q, abort_pend_d;
  logic [NCH-1:0][AW-1:0]  addr_q, addr_d;
  logic [NCH-1:0][AW-1:0]  len_q, len_d;
  logic [NCH-1:0][1:0]     size_q, size_d;
  logic                    bus_ch_q, bus_ch_d;
  logic [AW-1:0]           bus_addr_q, bus_addr_d;
  logic [1:0]              bus_size_q, bus_size_d;
  logic                    bus_last_q, bus_last_d;

  logic [NCH-1:0]          own_mask;
  logic [NCH-1:0]          pend;
  logic                    grant;
  logic [AW-1:0]           xfer_bytes;
  logic [AW-1:0]           len_left;

  // Size codes 2 and 3 both mean 4-byte transfers.
  function automatic logic [AW-1:0] size_bytes(input logic [1:0] s);
    logic [AW-1:0] b;
    case (s)
      2'd0:    b = AW'(1);
      2'd1:    b = AW'(2);
      default: b = AW'(4);
    endcase
    return b;
  endfunction

  // Next-state logic: per-channel config/start/abort handling, then the shared FSM.
  always_comb begin
    state_d      = state_q;
    last_ch_d    = last_ch_q;
    busy_d       = busy_q;
    done_d       = '0;
    abort_pend_d = abort_pend_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    bus_ch_d     = bus_ch_q;
    bus_addr_d   = bus_addr_q;
    bus_size_d   = bus_size_q;
    bus_last_d   = bus_last_q;
    own_mask     = '0;
    pend         = '0;
    grant        = 1'b0;
    xfer_bytes   = '0;
    len_left     = '0;

    // The channel that owns REQ/UPD finishes its transfer before an abort takes effect.
    if (state_q == S_REQ || state_q == S_UPD) own_mask[bus_ch_q] = 1'b1;

    for (int n = 0; n < NCH; n++) begin
      // A start in the same cycle wins over a config write, so start sees the old values.
      if (cfg_we && (cfg_ch == 1'(n)) && !busy_q[n] && !start[n]) begin
        addr_d[n] = cfg_addr;
        len_d[n]  = cfg_len;
        size_d[n] = cfg_size;
      end
      // An abort in the same cycle cancels the start.
      if (start[n] && !busy_q[n] && !abort[n]) begin
        if (len_q[n] != '0) busy_d[n] = 1'b1;
        else                done_d[n] = 1'b1;
      end
      if (abort[n] && busy_q[n] && !own_mask[n]) busy_d[n] = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (|busy_q) state_d = S_ARB;
      end
      S_ARB: begin
        pend = busy_q & ~abort;
        if (pend == '0) begin
          state_d = S_IDLE;
        end else begin
          grant        = (&pend) ? ~last_ch_q : pend[1];
          last_ch_d    = grant;
          bus_ch_d     = grant;
          bus_addr_d   = addr_q[grant];
          bus_size_d   = size_q[grant];
          bus_last_d   = (len_q[grant] <= size_bytes(size_q[grant]));
          abort_pend_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (abort[bus_ch_q]) abort_pend_d = 1'b1;
        if (bus_ack)         state_d      = S_UPD;
      end
      S_UPD: begin
        xfer_bytes       = size_bytes(size_q[bus_ch_q]);
        len_left         = (len_q[bus_ch_q] <= xfer_bytes) ? '0 : (len_q[bus_ch_q] - xfer_bytes);
        addr_d[bus_ch_q] = addr_q[bus_ch_q] - xfer_bytes;
        len_d[bus_ch_q]  = len_left;
        if (abort_pend_q || abort[bus_ch_q]) begin
          busy_d[bus_ch_q] = 1'b0;
        end else if (len_left == '0) begin
          busy_d[bus_ch_q] = 1'b0;
          done_d[bus_ch_q] = 1'b1;
        end
        abort_pend_d = 1'b0;
        state_d      = (|busy_d) ? S_ARB : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers. After reset, last_ch starts at 1 so that channel 0 wins the first tie.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_ch_q    <= 1'b1;
      busy_q       <= '0;
      done_q       <= '0;
      abort_pend_q <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      bus_ch_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_size_q   <= '0;
      bus_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_ch_q    <= last_ch_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_pend_q <= abort_pend_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      bus_ch_q     <= bus_ch_d;
      bus_addr_q   <= bus_addr_d;
      bus_size_q   <= bus_size_d;
      bus_last_q   <= bus_last_d;
    end
  end

  assign bus_req   = (state_q == S_REQ);
  assign bus_ch    = bus_ch_q;
  assign bus_addr  = bus_addr_q;
  assign bus_size  = bus_size_q;
  assign bus_last  = bus_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
